// File: rtl/tt_um_jarlo_tinytapeout1_pkg.sv
// Shared definitions for the tt_um_jarlo_tinytapeout1 tile.
// Holds:
//   - the ui_in bit-index constants
//   - the counter and prescaler widths
//   - the hex to 7-segment lookup table (segments a..g = bits 0..6, active-high)
package tt_um_jarlo_tinytapeout1_pkg;

  localparam int CNT_W = 8;   // counter and PWM width (only 8 is supported)
  localparam int PRE_W = 21;  // prescaler width: 3 x largest prescale code (7)

  // ui_in control bit positions
  localparam int RUN     = 0;
  localparam int DIR     = 1;  // 1 = up, 0 = down
  localparam int LOAD    = 2;
  localparam int NSEL    = 3;  // 0 = low nibble, 1 = high nibble
  localparam int PRE_LSB = 4;
  localparam int PRE_MSB = 6;
  localparam int RAW     = 7;

  localparam logic [6:0] SEG_LUT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/tt_um_jarlo_tinytapeout1_seg7_decoder.sv
// Hex digit to 7-segment decoder, purely combinational.
// Ports:
//   digit : 4-bit hex value in
//   seg   : segments a..g on bits 0..6, active-high
module tt_um_jarlo_tinytapeout1_seg7_decoder
  import tt_um_jarlo_tinytapeout1_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  assign seg = SEG_LUT[digit];

endmodule

// File: rtl/tt_um_jarlo_tinytapeout1.sv
// TinyTapeout user tile: 8-bit loadable up/down counter with a programmable
// prescaler, hex 7-segment display driver and PWM output.
//
// Configuration macro: JARLO_PWM_EN
//   - defined:   PWM counter present, uo_out[7] = pwm in 7-segment mode
//   - undefined: no PWM counter, uo_out[7] = 0 in 7-segment mode
//
// Ports:
//   clk     : system clock
//   rst_n   : asynchronous active-low reset
//   ena     : tile enable; all state holds while low
//   ui_in   : [0] run, [1] up/down, [2] load, [3] nibble select,
//             [6:4] prescale code p, [7] raw mode
//   uo_out  : {pwm, seg[6:0]} or the raw count
//   uio_in  : load value
//   uio_out : constant 0
//   uio_oe  : constant 0 (all uio pins are inputs)
module tt_um_jarlo_tinytapeout1
  import tt_um_jarlo_tinytapeout1_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic [PRE_W-1:0] pre_reg;
  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;
  logic [2:0]       pre_code;
  logic [7:0]       tick_cand;
  logic             tick;
  logic             pwm;
  logic [3:0]       digit;
  logic [6:0]       seg;

  assign pre_code = ui_in[PRE_MSB:PRE_LSB];

  // Prescaler: free-running while enabled, wraps naturally at 2^PRE_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_reg <= '0;
    end else if (ena) begin
      pre_reg <= pre_reg + PRE_W'(1);
    end
  end

  // Code p ticks when the low 3p prescaler bits are all ones, giving a
  // period of 2^(3p) cycles. Code 0 ticks every cycle.
  assign tick_cand[0] = 1'b1;
  generate
    for (genvar gi = 1; gi < 8; gi++) begin : g_tick
      assign tick_cand[gi] = &pre_reg[3*gi-1:0];
    end
  endgenerate
  assign tick = tick_cand[pre_code];

  // Load wins over stepping; wrap-around is plain modulo-256 arithmetic.
  always_comb begin
    count_next = count_reg;
    if (ui_in[LOAD]) begin
      count_next = uio_in;
    end else if (ui_in[RUN] && tick) begin
      if (ui_in[DIR]) begin
        count_next = count_reg + CNT_W'(1);
      end else begin
        count_next = count_reg - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (ena) begin
      count_reg <= count_next;
    end
  end

`ifdef JARLO_PWM_EN
  logic [CNT_W-1:0] pwm_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt_reg <= '0;
    end else if (ena) begin
      pwm_cnt_reg <= pwm_cnt_reg + CNT_W'(1);
    end
  end

  // High for count_reg out of every 256 cycles.
  assign pwm = (pwm_cnt_reg < count_reg);
`else
  assign pwm = 1'b0;
`endif

  assign digit = ui_in[NSEL] ? count_reg[7:4] : count_reg[3:0];

  tt_um_jarlo_tinytapeout1_seg7_decoder u_seg7_decoder (
    .digit (digit),
    .seg   (seg)
  );

  assign uo_out  = ui_in[RAW] ? count_reg : {pwm, seg};
  assign uio_out = '0;
  assign uio_oe  = '0;

endmodule

// File: tb/tb_tt_um_jarlo_tinytapeout1.sv
// Self-checking bench for tt_um_jarlo_tinytapeout1: directed steps followed
// by randomized control, compared against an arithmetic reference model.
module tb_tt_um_jarlo_tinytapeout1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int m_cnt;
  int m_pre;
  int m_pwm;

`ifdef JARLO_PWM_EN
  localparam bit PWM_ON = 1'b1;
`else
  localparam bit PWM_ON = 1'b0;
`endif

  tt_um_jarlo_tinytapeout1 dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
      4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
      8: return 7'h7F;  9: return 7'h6F;  10: return 7'h77; 11: return 7'h7C;
      12: return 7'h39; 13: return 7'h5E; 14: return 7'h79; default: return 7'h71;
    endcase
  endfunction

  function automatic logic [7:0] exp_uo();
    int  digit;
    bit  pwm;
    if (ui_in[7]) return 8'(m_cnt);
    digit = ui_in[3] ? (m_cnt / 16) : (m_cnt % 16);
    pwm   = PWM_ON && (m_pwm < m_cnt);
    return {pwm, seg_of(digit)};
  endfunction

  task automatic model_reset();
    m_cnt = 0;
    m_pre = 0;
    m_pwm = 0;
  endtask

  // One rising edge of the specified behaviour.
  task automatic model_step();
    int p;
    int period;
    bit tick;
    if (!ena) return;
    p      = int'(ui_in[6:4]);
    period = 1 << (3 * p);
    tick   = (p == 0) || ((m_pre % period) == period - 1);
    if (ui_in[2])
      m_cnt = int'(uio_in);
    else if (ui_in[0] && tick)
      m_cnt = ui_in[1] ? (m_cnt + 1) % 256 : (m_cnt + 255) % 256;
    m_pre = (m_pre + 1) % (1 << 21);
    m_pwm = (m_pwm + 1) % 256;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Advance one clock, update the model, then compare at the falling edge.
  task automatic cycle(input string tag);
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
    check(tag, 32'(uo_out), 32'(exp_uo()));
  endtask

  // Asynchronous reset asserted between edges; output must clear at once.
  task automatic pulse_reset();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("async_rst", 32'(uo_out), 32'(exp_uo()));
    cycle("in_rst");
    rst_n = 1'b1;
  endtask

  initial begin
    int hi;
    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    model_reset();

    // Reset state
    @(negedge clk);
    check("rst_seg", 32'(uo_out), 32'h3F);
    check("rst_oe", 32'(uio_oe), 32'h00);
    check("rst_uio_out", 32'(uio_out), 32'h00);
    ui_in = 8'h80;
    #1;
    check("rst_raw", 32'(uo_out), 32'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // Load and display
    uio_in = 8'hA5;
    ui_in  = 8'h84;
    cycle("load_a5");
    ui_in = 8'h80;
    #1;
    check("raw_a5", 32'(uo_out), 32'hA5);
    ui_in = 8'h00;
    #1;
    check("seg_lo", 32'(uo_out[6:0]), 32'h6D);
    ui_in = 8'h08;
    #1;
    check("seg_hi", 32'(uo_out[6:0]), 32'h77);
    @(negedge clk);

    // Up count, p = 0
    uio_in = 8'hFE;
    ui_in  = 8'h84;
    cycle("load_fe");
    ui_in = 8'h83;
    cycle("up1"); check("up_ff", 32'(uo_out), 32'hFF);
    cycle("up2"); check("up_00", 32'(uo_out), 32'h00);
    cycle("up3"); check("up_01", 32'(uo_out), 32'h01);

    // Down count
    uio_in = 8'h01;
    ui_in  = 8'h84;
    cycle("load_01");
    ui_in = 8'h81;
    cycle("dn1"); check("dn_00", 32'(uo_out), 32'h00);
    cycle("dn2"); check("dn_ff", 32'(uo_out), 32'hFF);

    // Mid-operation reset, then prescaler p = 1 from a clean start
    pulse_reset();
    ui_in = 8'h93;
    for (int i = 0; i < 32; i++) cycle("pre1");
    check("pre1_cnt", 32'(uo_out), 32'h04);
    ena = 1'b0;
    for (int i = 0; i < 10; i++) cycle("ena_off");
    check("ena_hold", 32'(uo_out), 32'h04);
    ena = 1'b1;

    // PWM duty
    uio_in = 8'h40;
    ui_in  = 8'h04;
    cycle("load_40");
    ui_in = 8'h00;
    hi = 0;
    for (int i = 0; i < 256; i++) begin
      cycle("pwm40");
      hi += int'(uo_out[7]);
    end
    check("pwm40_high", 32'(hi), PWM_ON ? 32'd64 : 32'd0);
    uio_in = 8'h00;
    ui_in  = 8'h04;
    cycle("load_00");
    ui_in = 8'h00;
    hi = 0;
    for (int i = 0; i < 256; i++) begin
      cycle("pwm00");
      hi += int'(uo_out[7]);
    end
    check("pwm00_high", 32'(hi), 32'd0);

    // Randomized control against the model
    for (int i = 0; i < 1500; i++) begin
      ui_in = 8'($urandom);
      if ($urandom_range(0, 7) != 0) ui_in[2] = 1'b0;
      ui_in[6:4] = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7))
                                               : 3'($urandom_range(0, 1));
      uio_in = 8'($urandom);
      ena    = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 199) == 0) begin
        ena = 1'b1;
        pulse_reset();
      end
      cycle("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
